// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one synchronous data memory between the CPU MEM stage and a loader/debug port
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  localparam logic CPU = 1'b0;
  localparam logic DBG = 1'b1;
  state_t state, state_nx;
  logic owner, last_owner, cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic cpu_elig, dbg_elig, grant, gnt_dbg;
  // the port being answered in RESP may not win the immediate re-grant
  always_comb begin
    cpu_elig = cpu_req & ~dbg_lock & ~((state == RESP) & (owner == CPU));
    dbg_elig = dbg_req & ~((state == RESP) & (owner == DBG));
    gnt_dbg  = (cpu_elig & dbg_elig) ? (last_owner == CPU) : dbg_elig;
    grant    = (state != ISSUE) & (cpu_elig | dbg_elig);
    state_nx = grant ? ISSUE : (state == ISSUE) ? RESP : IDLE;
  end
  always_ff @(posedge clock)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clock)
    if (!reset) begin
      owner      <= CPU;
      last_owner <= DBG;
      cmd_we     <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
    end else if (grant) begin
      owner      <= gnt_dbg;
      last_owner <= gnt_dbg;
      cmd_we     <= gnt_dbg ? dbg_we : cpu_we;
      cmd_addr   <= gnt_dbg ? dbg_addr : cpu_addr;
      cmd_wdata  <= gnt_dbg ? dbg_wdata : cpu_wdata;
    end
  // gating with reset keeps an access caught by reset from touching memory or acking
  always_comb begin
    mem_en    = reset & (state == ISSUE);
    mem_we    = mem_en & cmd_we;
    mem_addr  = cmd_addr;
    mem_wdata = cmd_wdata;
    cpu_ack   = reset & (state == RESP) & (owner == CPU);
    dbg_ack   = reset & (state == RESP) & (owner == DBG);
    cpu_rdata = cpu_ack ? mem_rdata : '0;
    dbg_rdata = dbg_ack ? mem_rdata : '0;
    cpu_stall = cpu_req & ~cpu_ack;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a transaction-level model
module tb_dmem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  logic clock = 1'b0, reset = 1'b0;
  logic cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
  logic [AW-1:0] cpu_addr = '0, dbg_addr = '0, mem_addr;
  logic [DW-1:0] cpu_wdata = '0, dbg_wdata = '0, cpu_rdata, dbg_rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic cpu_ack, cpu_stall, dbg_ack, mem_en, mem_we;
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] ref_mem [0:255];
  logic ld_en = 1'b0;
  logic [AW-1:0] ld_a = '0;
  logic [DW-1:0] ld_d = '0;
  int errors = 0, checks = 0;
  int cpu_acks = 0, dbg_acks = 0, cpu_seen = 0, dbg_seen = 0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    if (ld_en) mem[ld_a] <= ld_d;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end

  // model: one outstanding transaction, aged 1 in its memory cycle and 2 in its answer cycle
  logic m_busy = 1'b0, m_own = 1'b0, m_last = 1'b1, m_we = 1'b0;
  int m_age = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic m_resp, ce, de, gd, e_en, e_cack, e_dack;
  assign m_resp = m_busy && m_age == 2;
  assign ce = cpu_req && !dbg_lock && !(m_resp && !m_own);
  assign de = dbg_req && !(m_resp && m_own);
  assign gd = (ce && de) ? !m_last : de;
  assign e_en = reset && m_busy && m_age == 1;
  assign e_cack = reset && m_resp && !m_own;
  assign e_dack = reset && m_resp && m_own;

  always @(posedge clock) begin
    if (ld_en) ref_mem[ld_a] <= ld_d;
    if (e_en && m_we) ref_mem[m_addr] <= m_wdata;
    if (!reset) begin
      m_busy <= 1'b0;
      m_last <= 1'b1;
    end else if ((!m_busy || m_resp) && (ce || de)) begin
      m_busy <= 1'b1;
      m_age <= 1;
      m_own <= gd;
      m_last <= gd;
      m_we <= gd ? dbg_we : cpu_we;
      m_addr <= gd ? dbg_addr : cpu_addr;
      m_wdata <= gd ? dbg_wdata : cpu_wdata;
    end else if (m_busy && m_age == 1) m_age <= 2;
    else m_busy <= 1'b0;
  end

  task automatic chk(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_en && m_we);
    if (e_en) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("cpu_ack", cpu_ack, e_cack);
    chk("dbg_ack", dbg_ack, e_dack);
    chk("cpu_stall", cpu_stall, cpu_req && !e_cack);
    if (!(e_cack && m_we)) chk("cpu_rdata", cpu_rdata, e_cack ? ref_mem[m_addr] : '0);
    if (!(e_dack && m_we)) chk("dbg_rdata", dbg_rdata, e_dack ? ref_mem[m_addr] : '0);
    if (cpu_ack) cpu_acks++;
    if (dbg_ack) dbg_acks++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      ld_en = 1'b1;
      ld_a = AW'(i);
      ld_d = (i == 5) ? 32'h0000_002A : $urandom;
      tick();
    end
    ld_en = 1'b0;
    tick();
    tick();
    // lone CPU read of the preloaded word
    reset = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd5;
    @(negedge clock); chk("rd5 en idle", mem_en, 1'b0); chk("rd5 stall0", cpu_stall, 1'b1);
    tick(); @(negedge clock); chk("rd5 en issue", mem_en, 1'b1); chk("rd5 stall1", cpu_stall, 1'b1);
    tick(); @(negedge clock); chk("rd5 ack", cpu_ack, 1'b1); chk("rd5 data", cpu_rdata, 32'h2A);
    chk("rd5 stall2", cpu_stall, 1'b0);
    tick(); cpu_req = 1'b0;
    // write then read back
    tick(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'd3; cpu_wdata = 32'h11;
    tick(); @(negedge clock); chk("wr3 we", mem_we, 1'b1);
    tick(); @(negedge clock); chk("wr3 ack", cpu_ack, 1'b1);
    tick(); cpu_we = 1'b0;
    tick(); @(negedge clock); chk("rd3 en", mem_en, 1'b1); chk("rd3 we", mem_we, 1'b0);
    tick(); @(negedge clock); chk("rd3 ack", cpu_ack, 1'b1); chk("rd3 data", cpu_rdata, 32'h11);
    tick(); cpu_req = 1'b0;
    // both held from reset: alternating acks
    reset = 1'b0;
    tick(); reset = 1'b1; cpu_req = 1'b1; dbg_req = 1'b1; dbg_we = 1'b0; cpu_addr = 8'd1; dbg_addr = 8'd2;
    for (int c = 0; c < 9; c++) begin
      @(negedge clock);
      chk("tie cpu_ack", cpu_ack, c == 2 || c == 6);
      chk("tie dbg_ack", dbg_ack, c == 4 || c == 8);
      tick();
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    // lock-out then release
    reset = 1'b0;
    tick(); reset = 1'b1; dbg_lock = 1'b1; cpu_req = 1'b1; cpu_addr = 8'd5;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock); chk("lock en", mem_en, 1'b0); chk("lock stall", cpu_stall, 1'b1);
      tick();
    end
    dbg_lock = 1'b0;
    @(negedge clock); chk("unlock ack0", cpu_ack, 1'b0);
    tick(); @(negedge clock); chk("unlock en", mem_en, 1'b1);
    tick(); @(negedge clock); chk("unlock ack", cpu_ack, 1'b1); chk("unlock data", cpu_rdata, 32'h2A);
    tick(); cpu_req = 1'b0;
    // reset in the middle of a debug write
    tick(); dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'd7; dbg_wdata = 32'hDEAD_BEEF;
    tick(); reset = 1'b0;
    @(negedge clock); chk("rst en", mem_en, 1'b0); chk("rst dack0", dbg_ack, 1'b0);
    tick(); dbg_req = 1'b0;
    @(negedge clock); chk("rst dack1", dbg_ack, 1'b0); chk("rst en1", mem_en, 1'b0);
    tick(); reset = 1'b1; cpu_req = 1'b1; dbg_req = 1'b1; dbg_we = 1'b0; cpu_we = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("post cpu_ack", cpu_ack, c == 2);
      chk("post dbg_ack", dbg_ack, 1'b0);
      tick();
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    cpu_seen = cpu_acks; dbg_seen = dbg_acks;
    repeat (4000) begin
      reset = ($urandom_range(0, 299) != 0);
      if (!reset) begin
        cpu_req = 1'b0;
        dbg_req = 1'b0;
      end else begin
        if (cpu_req && cpu_acks != cpu_seen) cpu_req = 1'b0;
        if (dbg_req && dbg_acks != dbg_seen) dbg_req = 1'b0;
        if (!cpu_req && $urandom_range(0, 2) == 0) begin
          cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
          cpu_addr = AW'($urandom_range(0, 15)); cpu_wdata = $urandom;
        end
        if (!dbg_req && $urandom_range(0, 2) == 0) begin
          dbg_req = 1'b1; dbg_we = 1'($urandom_range(0, 1));
          dbg_addr = AW'($urandom_range(0, 15)); dbg_wdata = $urandom;
        end
        if ($urandom_range(0, 19) == 0) dbg_lock = !dbg_lock;
      end
      cpu_seen = cpu_acks; dbg_seen = dbg_acks;
      tick();
    end
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
